// File: rtl/idct_8x8.sv
// idct_8x8: separable 8x8 inverse DCT (row pass, then column pass)
// on one serial MAC; loads 64 Q8.8 coefficients, streams 64 pixels.
module idct_8x8 #(
    parameter int DATA_W      = 16,
    parameter int COEF_FRAC   = 14,
    parameter int LEVEL_SHIFT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              busy,
    output logic              block_done
);

    localparam int PROD_W = DATA_W + 16;
    localparam int ACC_W  = PROD_W + 3;
    localparam int PIX_W  = DATA_W - 8 + 3;

    localparam logic signed [ACC_W-1:0] RND    = ACC_W'(1) <<< (COEF_FRAC - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI - ACC_W'(1);

    // C[k][n], indexed {k, n}
    localparam logic signed [15:0] C_ROM [64] = '{
        16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,
        16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,
        16'sd8035,  16'sd6811,  16'sd4551,  16'sd1598,
        -16'sd1598, -16'sd4551, -16'sd6811, -16'sd8035,
        16'sd7568,  16'sd3135,  -16'sd3135, -16'sd7568,
        -16'sd7568, -16'sd3135, 16'sd3135,  16'sd7568,
        16'sd6811,  -16'sd1598, -16'sd8035, -16'sd4551,
        16'sd4551,  16'sd8035,  16'sd1598,  -16'sd6811,
        16'sd5793,  -16'sd5793, -16'sd5793, 16'sd5793,
        16'sd5793,  -16'sd5793, -16'sd5793, 16'sd5793,
        16'sd4551,  -16'sd8035, 16'sd1598,  16'sd6811,
        -16'sd6811, -16'sd1598, 16'sd8035,  -16'sd4551,
        16'sd3135,  -16'sd7568, 16'sd7568,  -16'sd3135,
        -16'sd3135, 16'sd7568,  -16'sd7568, 16'sd3135,
        16'sd1598,  -16'sd4551, 16'sd6811,  -16'sd8035,
        16'sd8035,  -16'sd6811, 16'sd4551,  -16'sd1598
    };

    typedef enum logic [1:0] {S_LOAD, S_ROW, S_COL, S_OUT} state_t;

    state_t r_state;
    state_t w_next;

    logic signed [DATA_W-1:0] r_buf_a [64];
    logic signed [DATA_W-1:0] r_buf_b [64];
    logic [5:0]               r_idx;
    logic [2:0]               r_line;
    logic [2:0]               r_outn;
    logic [3:0]               r_k;
    logic signed [ACC_W-1:0]  r_acc;
    logic [7:0]               r_out_data;
    logic                     r_busy;

    logic                     w_in_hs;
    logic                     w_out_hs;
    logic                     w_mac_run;
    logic                     w_wr_step;
    logic                     w_pass_end;
    logic signed [DATA_W-1:0] w_op;
    logic signed [15:0]       w_coef;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_acc_base;
    logic signed [ACC_W-1:0]  w_rnd;
    logic signed [DATA_W-1:0] w_sat;

    // Q8.8 -> nearest integer, plus level shift, clipped to 0..255
    function automatic logic [7:0] pix(input logic signed [DATA_W-1:0] a);
        logic [DATA_W:0]         s;
        logic signed [PIX_W-1:0] t;
        s = {a[DATA_W-1], a} + (DATA_W + 1)'(128);
        t = PIX_W'($signed(s[DATA_W:8])) + PIX_W'(LEVEL_SHIFT);
        if (t[PIX_W-1])
            pix = 8'd0;
        else if (t[PIX_W-2:8] != '0)
            pix = 8'd255;
        else
            pix = t[7:0];
    endfunction

    assign w_in_hs    = in_valid && (r_state == S_LOAD);
    assign w_out_hs   = out_ready && (r_state == S_OUT);
    assign w_mac_run  = (r_state == S_ROW) || (r_state == S_COL);
    assign w_wr_step  = (r_k == 4'd8);
    assign w_pass_end = w_wr_step && (r_line == 3'd7) && (r_outn == 3'd7);

    always_comb begin
        w_op = r_buf_a[{r_line, r_k[2:0]}];
        if (r_state == S_COL)
            w_op = r_buf_b[{r_k[2:0], r_line}];
    end

    assign w_coef     = C_ROM[{r_k[2:0], r_outn}];
    assign w_prod     = w_op * w_coef;
    assign w_acc_base = (r_k == 4'd0) ? '0 : r_acc;
    assign w_rnd      = (r_acc + RND) >>> COEF_FRAC;

    always_comb begin
        w_sat = w_rnd[DATA_W-1:0];
        if (w_rnd > SAT_HI)
            w_sat = {1'b0, {(DATA_W - 1){1'b1}}};
        else if (w_rnd < SAT_LO)
            w_sat = {1'b1, {(DATA_W - 1){1'b0}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_LOAD;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_LOAD:  if (w_in_hs && r_idx == 6'd63) w_next = S_ROW;
            S_ROW:   if (w_pass_end) w_next = S_COL;
            S_COL:   if (w_pass_end) w_next = S_OUT;
            S_OUT:   if (w_out_hs && r_idx == 6'd63) w_next = S_LOAD;
            default: w_next = S_LOAD;
        endcase
    end

    always_comb begin
        in_ready   = (r_state == S_LOAD);
        out_valid  = (r_state == S_OUT);
        out_data   = r_out_data;
        busy       = r_busy;
        block_done = w_out_hs && (r_idx == 6'd63);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_line     <= '0;
            r_outn     <= '0;
            r_k        <= '0;
            r_acc      <= '0;
            r_out_data <= '0;
            r_busy     <= 1'b0;
        end else begin
            if (w_in_hs) begin
                r_idx  <= r_idx + 6'd1;
                r_busy <= 1'b1;
            end
            if (w_out_hs) begin
                r_idx <= r_idx + 6'd1;
                if (r_idx == 6'd63)
                    r_busy <= 1'b0;
                else
                    r_out_data <= pix(r_buf_a[r_idx + 6'd1]);
            end
            // A[0] is final long before the column pass ends
            if (r_state == S_COL && w_pass_end)
                r_out_data <= pix(r_buf_a[0]);
            if (w_mac_run) begin
                if (w_wr_step) begin
                    r_k    <= '0;
                    r_outn <= r_outn + 3'd1;
                    if (r_outn == 3'd7)
                        r_line <= r_line + 3'd1;
                end else begin
                    r_k   <= r_k + 4'd1;
                    r_acc <= w_acc_base + ACC_W'(w_prod);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_hs)
            r_buf_a[r_idx] <= in_data;
        else if (r_state == S_COL && w_wr_step)
            r_buf_a[{r_outn, r_line}] <= w_sat;
        if (r_state == S_ROW && w_wr_step)
            r_buf_b[{r_line, r_outn}] <= w_sat;
    end

endmodule

// File: tb/tb_idct_8x8.sv
// tb_idct_8x8: directed checks of idct_8x8 across three level-shift
// builds running in lockstep on shared stimulus.
module tb_idct_8x8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_data;

    logic       rdy0, ov0, bs0, bd0;
    logic       rdy1, ov1, bs1, bd1;
    logic       rdy2, ov2, bs2, bd2;
    logic [7:0] od0, od1, od2;

    always #5 clk = ~clk;

    idct_8x8 #(.LEVEL_SHIFT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .busy(bs0), .block_done(bd0)
    );

    idct_8x8 #(.LEVEL_SHIFT(128)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .busy(bs1), .block_done(bd1)
    );

    idct_8x8 #(.LEVEL_SHIFT(250)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
        .busy(bs2), .block_done(bd2)
    );

    int          n_tot = 0;
    int          n_bad = 0;
    logic [15:0] blk [64];
    int          px0 [64];
    int          px1 [64];
    int          px2 [64];
    int          xpix [64];

    task automatic chk(input string tag, input int got, input int exp);
        n_tot++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic async_rst(input string tag);
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk({tag, "_in_ready"}, int'(rdy0), 1);
        chk({tag, "_out_valid"}, int'(ov0), 0);
        chk({tag, "_busy"}, int'(bs0), 0);
        chk({tag, "_out_data0"}, int'(od0), 0);
        chk({tag, "_out_data1"}, int'(od1), 0);
        chk({tag, "_block_done"}, int'(bd0), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_blk(input bit stress);
        int i;
        int guard;
        i = 0;
        guard = 0;
        while (i < 64 && guard < 1000) begin
            @(negedge clk);
            guard++;
            if (stress && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = blk[i];
                if (rdy0) i++;
            end
        end
        chk("load_accepted", i, 64);
    endtask

    task automatic run_block(input string tag, input bit stress);
        int cyc, p, lat, n_done, ir_bad, hold_bad, lock_bad, busy_cnt;
        bit holding;
        logic [7:0] held;
        load_blk(stress);
        cyc = 0; p = 0; lat = -1; n_done = 0; ir_bad = 0;
        hold_bad = 0; lock_bad = 0; busy_cnt = 0;
        holding = 1'b0; held = '0;
        while (p < 64 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            in_valid = stress;
            in_data  = 16'($urandom);
            if (rdy0) ir_bad++;
            if (bs0) busy_cnt++;
            if (ov0 && lat < 0) lat = cyc;
            if (holding && od0 !== held) hold_bad++;
            if (ov1 !== ov0 || ov2 !== ov0 || rdy1 !== rdy0 || rdy2 !== rdy0 ||
                bs1 !== bs0 || bs2 !== bs0) lock_bad++;
            out_ready = stress ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (bd1 !== bd0 || bd2 !== bd0) lock_bad++;
            if (bd0) n_done++;
            if (ov0 && out_ready) begin
                px0[p] = od0;
                px1[p] = od1;
                px2[p] = od2;
                p++;
            end
            holding = ov0 && !out_ready;
            held    = od0;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk({tag, "_pixels"}, p, 64);
        chk({tag, "_latency"}, lat, 1153);
        chk({tag, "_done_pulses"}, n_done, 1);
        chk({tag, "_in_ready_low"}, ir_bad, 0);
        chk({tag, "_stall_hold"}, hold_bad, 0);
        chk({tag, "_lockstep"}, lock_bad, 0);
        chk({tag, "_busy_cycles"}, busy_cnt, cyc);
        chk({tag, "_busy_after"}, int'(bs0), 0);
        chk({tag, "_in_ready_after"}, int'(rdy0), 1);
        chk({tag, "_out_valid_after"}, int'(ov0), 0);
    endtask

    task automatic check_flat(input string tag, input int e0, input int e1, input int e2);
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("%s_ls0_px%0d", tag, i), px0[i], e0);
            chk($sformatf("%s_ls128_px%0d", tag, i), px1[i], e1);
            chk($sformatf("%s_ls250_px%0d", tag, i), px2[i], e2);
        end
    endtask

    function automatic int tol_err(input int got, input int exp);
        int d;
        d = got - exp;
        return (d > 1 || d < -1) ? d : 0;
    endfunction

    task automatic check_rt(input string tag);
        int e2;
        for (int i = 0; i < 64; i++) begin
            e2 = (xpix[i] + 250 > 255) ? 255 : xpix[i] + 250;
            chk($sformatf("%s_ls0_err%0d", tag, i), tol_err(px0[i], xpix[i]), 0);
            chk($sformatf("%s_ls128_err%0d", tag, i), tol_err(px1[i], xpix[i] + 128), 0);
            chk($sformatf("%s_ls250_err%0d", tag, i), tol_err(px2[i], e2), 0);
        end
    endtask

    task automatic set_dc(input logic [15:0] v);
        for (int i = 0; i < 64; i++) blk[i] = 16'h0000;
        blk[0] = v;
    endtask

    // floating-point forward DCT of xpix, quantised to Q8.8
    task automatic make_rt_blk();
        real pi, s, au, av, q;
        pi = 3.14159265358979;
        for (int i = 0; i < 64; i++)
            xpix[i] = ((i / 8) * 3 + (i % 8) * 5 + (i / 8) * (i % 8)) % 16;
        for (int u = 0; u < 8; u++) begin
            for (int v = 0; v < 8; v++) begin
                s = 0.0;
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++)
                        s = s + xpix[r * 8 + c] *
                            $cos((2 * r + 1) * u * pi / 16.0) *
                            $cos((2 * c + 1) * v * pi / 16.0);
                au = (u == 0) ? $sqrt(0.125) : 0.5;
                av = (v == 0) ? $sqrt(0.125) : 0.5;
                q  = s * au * av * 256.0;
                blk[u * 8 + v] = 16'($rtoi(q >= 0.0 ? q + 0.5 : q - 0.5));
            end
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        async_rst("por");

        set_dc(16'h4000);
        run_block("dc", 1'b0);
        check_flat("dc", 8, 136, 255);

        async_rst("midclk");

        set_dc(16'h8000);
        run_block("neg", 1'b0);
        check_flat("neg", 0, 112, 234);

        make_rt_blk();
        run_block("rt", 1'b0);
        check_rt("rt");

        run_block("stress", 1'b1);
        check_rt("stress");

        load_blk(1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (800) @(negedge clk);
        async_rst("abort");
        set_dc(16'h4000);
        run_block("post_abort", 1'b0);
        check_flat("post_abort", 8, 136, 255);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/idct_8x8.md
Name: idct_8x8

Overview:
- Inverse of the forward 8x8 DCT path.
- Accepts one 8x8 block of signed Q8.8 DCT coefficients, matching the 16-bit [23:8] slice format the forward DCT writes to image memory.
- Performs a separable 2-D orthonormal IDCT: a row pass, then a column pass, through a shared serial MAC.
- Streams out 64 reconstructed 8-bit pixels. Sits between coefficient memory and the image write-back/display path.

Parameters:
- DATA_W, 16, coefficient and intermediate width (signed, 8 fractional bits).
- COEF_FRAC, 14, fractional bits of the basis ROM constants.
- LEVEL_SHIFT, 0, unsigned integer added to each pixel before clipping (0..255).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  coefficient valid.
- in_ready  out  1  block can accept a coefficient.
- in_data  in  16  signed Q8.8 coefficient; row-major, k_row then k_col.
- out_valid  out  1  pixel valid.
- out_ready  in  1  downstream accepts pixel.
- out_data  out  8  unsigned pixel; row-major spatial order.
- busy  out  1  high from first accepted coefficient until last pixel accepted.
- block_done  out  1  one-cycle pulse on the cycle the 64th pixel handshake occurs.

Behaviour:
- Reset (async, rst_n=0): state=LOAD, all counters 0, in_ready=1, out_valid=0, out_data=0, busy=0, block_done=0. Buffer contents are don't-care.
- Reset mid-operation aborts the block. The next block starts fresh from LOAD.
- Storage: buffer A (64x16) holds coefficients and the column-pass result. Buffer B (64x16) holds the row-pass result.
- ROM: C[k][n] = round(2^14 * a(k) * cos((2n+1)k*pi/16)), 16-bit signed, with a(0)=sqrt(1/8) and a(k>0)=1/2. Example: C[0][n]=5793, C[1][0]=8035, C[4][0]=5793, C[4][1]=-5793.
- FSM is LOAD -> ROW -> COL -> OUT -> LOAD.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready writes A[idx], idx=0..63.
  - The handshake at idx=63 moves to ROW on the next cycle, with in_ready=0 from that cycle.
  - busy rises on the first handshake.
- ROW:
  - For each row r (0..7) and each output n (0..7): 8 cycles accumulate sum_k A[r*8+k]*C[k][n], then 1 cycle round/saturate/write B[r*8+n]. That is 9 cycles per output and 576 cycles total.
- COL:
  - Same schedule on columns: for column c and output m, accumulate sum_k B[k*8+c]*C[k][m], then write A[m*8+c]. 576 cycles.
- Arithmetic:
  - Product is 16x16 -> 32-bit signed. Accumulator is 35-bit signed, cleared at the start of each output.
  - Rounding: add 2^13, arithmetic shift right 14.
  - Saturate to 16-bit signed (-32768..32767) before writing.
- OUT:
  - out_valid=1.
  - out_data = clip(((A[p]+128)>>>8) + LEVEL_SHIFT, 0, 255), where p runs 0..63 and >>> is an arithmetic shift.
  - Computed with at least 10-bit signed headroom. Registered and stable while out_valid&!out_ready.
  - p advances only on handshake. The handshake at p=63 pulses block_done, drops out_valid and busy, and returns to LOAD with in_ready=1 on the next cycle.
- Latency: first out_valid asserts exactly 1153 clocks after the cycle of the 64th input handshake (1152 compute cycles + 1 register).
- Back-pressure:
  - out_ready=0 holds p and out_data indefinitely, with no data loss.
  - in_valid is ignored outside LOAD.
- No input/output overlap: a new block cannot load until OUT completes.

Test Plan:
- Reset: rst_n=0 asynchronously mid-clock -> in_ready=1, out_valid=0, busy=0, out_data=0 immediately. Release, feed block -> normal operation.
- DC block: X[0][0]=16'h4000, all others 0, LEVEL_SHIFT=0 -> row-pass B[0..7]=5793, final A=2048 in all 64 entries. All 64 pixels=8. First out_valid exactly 1153 cycles after the 64th input. block_done pulses once.
- Clipping: X[0][0]=16'h8000 -> all pixels 0. Separate build LEVEL_SHIFT=250 with X[0][0]=16'h4000 -> all pixels 255. Same build, DC 16'h4000 with LEVEL_SHIFT=128 -> all 136.
- AC/round-trip: a single random 8x8 pixel block is passed through a floating-point forward DCT model and quantised to Q8.8, then fed to the block -> every pixel within +/-1 of the original.
- Handshake stress: random in_valid gaps during LOAD and random out_ready stalls during OUT -> output sequence identical to the no-stall run. out_data is held stable during each stall. in_ready=0 throughout ROW/COL/OUT even with in_valid=1.
- Abort: assert rst_n=0 during COL, then load the DC block -> correct output of 8s with no residue from the aborted block.
